// File: rtl/clkdiv_multi.sv
// clkdiv_multi: multi-channel programmable clock-enable divider.
// Each channel emits a one-cycle tick every (D+1) enabled cycles plus a toggle that flips on every tick.
module clkdiv_multi #(
  parameter int NUM_CH  = 3,
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 15,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_data,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] toggle
);

  logic [NUM_CH-1:0][CNT_W-1:0] div_q, div_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            tick_q, tick_d;
  logic [NUM_CH-1:0]            toggle_q, toggle_d;

  // Per-channel counter/tick/toggle next state and divisor write
  always_comb begin
    div_d    = div_q;
    cnt_d    = cnt_q;
    tick_d   = {NUM_CH{1'b0}};
    toggle_d = toggle_q;
    for (int i = 0; i < NUM_CH; i++) begin
      // Reloads read div_q, so a same-edge write only lands at the following reload.
      if (sync) begin
        cnt_d[i]    = div_q[i];
        toggle_d[i] = 1'b0;
      end else if (en[i]) begin
        if (cnt_q[i] == {CNT_W{1'b0}}) begin
          cnt_d[i]    = div_q[i];
          tick_d[i]   = 1'b1;
          toggle_d[i] = ~toggle_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end

      if (wr_en && (wr_ch == CH_W'(i))) begin
        div_d[i] = wr_data;
      end else begin
        div_d[i] = div_q[i];
      end
    end
  end

  // State registers with asynchronous reset to the default divisor
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      div_q    <= {NUM_CH{CNT_W'(DEF_DIV)}};
      cnt_q    <= {NUM_CH{CNT_W'(DEF_DIV)}};
      tick_q   <= {NUM_CH{1'b0}};
      toggle_q <= {NUM_CH{1'b0}};
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      toggle_q <= toggle_d;
    end
  end

  assign tick   = tick_q;
  assign toggle = toggle_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi: period-counting reference model plus pinned literal expectations.
module tb_clkdiv_multi;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 2;

  logic              clk;
  logic              arst_n;
  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_data;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] toggle;

  int errors = 0;
  int checks = 0;

  // Reference model: counts enabled edges up toward the period latched at the last restart.
  int          div_m   [NUM_CH];
  int          edges_m [NUM_CH];
  int          per_m   [NUM_CH];
  logic [NUM_CH-1:0] tick_m;
  logic [NUM_CH-1:0] tog_m;

  clkdiv_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(15)) dut (
    .clk(clk), .arst_n(arst_n), .en(en), .sync(sync), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_data(wr_data), .tick(tick), .toggle(toggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input logic [NUM_CH-1:0] mask,
                     input logic [NUM_CH-1:0] exp, input logic [NUM_CH-1:0] act);
    chk(name, act & mask, exp & mask);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      div_m[i]   = 15;
      edges_m[i] = 0;
      per_m[i]   = 16;
    end
    tick_m = '0;
    tog_m  = '0;
  endtask

  task automatic model_edge();
    int old_div [NUM_CH];
    for (int i = 0; i < NUM_CH; i++) old_div[i] = div_m[i];
    for (int i = 0; i < NUM_CH; i++) begin
      tick_m[i] = 1'b0;
      if (sync) begin
        edges_m[i] = 0;
        per_m[i]   = old_div[i] + 1;
        tog_m[i]   = 1'b0;
      end else if (en[i]) begin
        edges_m[i]++;
        if (edges_m[i] == per_m[i]) begin
          tick_m[i]  = 1'b1;
          tog_m[i]   = ~tog_m[i];
          edges_m[i] = 0;
          per_m[i]   = old_div[i] + 1;
        end
      end
    end
    if (wr_en && int'(wr_ch) < NUM_CH) div_m[wr_ch] = int'(wr_data);
  endtask

  // One clock edge: update model, then compare outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("tick_model", tick, tick_m);
    chk("toggle_model", toggle, tog_m);
  endtask

  task automatic drive(input int n);
    en      = (n >= 72 && n <= 76) ? 3'b011 : 3'b111;
    sync    = (n == 54 || n == 100);
    wr_en   = 1'b0;
    wr_ch   = 2'd0;
    wr_data = 16'd0;
    case (n)
      21:      begin wr_en = 1'b1; wr_ch = 2'd1; wr_data = 16'd3; end
      51:      begin wr_en = 1'b1; wr_ch = 2'd0; wr_data = 16'd0; end
      52:      begin wr_en = 1'b1; wr_ch = 2'd2; wr_data = 16'd7; end
      95:      begin wr_en = 1'b1; wr_ch = 2'd0; wr_data = 16'd5; end
      112:     begin wr_en = 1'b1; wr_ch = 2'd3; wr_data = 16'd1; end
      default: wr_en = 1'b0;
    endcase
  endtask

  task automatic pins(input int n);
    case (n)
      15:  pin("c15_no_tick", 3'b111, 3'b000, tick);
      16:  begin pin("c16_first_tick", 3'b111, 3'b111, tick); pin("c16_toggle", 3'b111, 3'b111, toggle); end
      32:  pin("c32_all_tick", 3'b111, 3'b111, tick);
      35:  pin("c35_ch1_quiet", 3'b010, 3'b000, tick);
      36:  pin("c36_ch1_only", 3'b111, 3'b010, tick);
      40:  pin("c40_ch1_p4", 3'b010, 3'b010, tick);
      54:  begin pin("c54_sync_tick", 3'b111, 3'b000, tick); pin("c54_sync_tog", 3'b111, 3'b000, toggle); end
      55:  begin pin("c55_ch0_tick", 3'b001, 3'b001, tick); pin("c55_ch0_tog", 3'b001, 3'b001, toggle); end
      56:  begin pin("c56_ch0_tick", 3'b001, 3'b001, tick); pin("c56_ch0_tog", 3'b001, 3'b000, toggle); end
      58:  pin("c58_ch1_first", 3'b010, 3'b010, tick);
      62:  pin("c62_ch2_first", 3'b100, 3'b100, tick);
      74:  pin("c74_ch2_paused", 3'b100, 3'b000, tick);
      78:  pin("c78_ch2_delayed", 3'b100, 3'b000, tick);
      83:  pin("c83_ch2_resume", 3'b100, 3'b100, tick);
      91:  pin("c91_ch2_p8", 3'b100, 3'b100, tick);
      100: begin pin("c100_sync_tick", 3'b111, 3'b000, tick); pin("c100_sync_tog", 3'b111, 3'b000, toggle); end
      103: pin("c103_none", 3'b111, 3'b000, tick);
      104: pin("c104_ch1", 3'b111, 3'b010, tick);
      106: pin("c106_ch0", 3'b111, 3'b001, tick);
      108: pin("c108_ch1_ch2", 3'b111, 3'b110, tick);
      118: pin("c118_ch0_p6", 3'b001, 3'b001, tick);
      default: ;
    endcase
  endtask

  initial begin
    arst_n = 1'b0; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tick", tick, 3'b000);
    chk("reset_toggle", toggle, 3'b000);
    #2 arst_n = 1'b1;

    for (int n = 1; n <= 121; n++) begin
      drive(n);
      step();
      pins(n);
    end

    // Reset asserted mid-period: outputs clear immediately, default divisor restored.
    #2 arst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_tick", tick, 3'b000);
    chk("midrst_toggle", toggle, 3'b000);
    en = 3'b111; sync = 1'b0; wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #3 arst_n = 1'b1;
    for (int m = 1; m <= 16; m++) begin
      step();
      if (m == 15) pin("r15_no_tick", 3'b111, 3'b000, tick);
      if (m == 16) pin("r16_def_tick", 3'b111, 3'b111, tick);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
